fp_scoreboard: RTL

FP_SCOREBOARD -- requirements
Module: fp_scoreboard

---
 rtl/fp_scoreboard_if.sv | 28 ++
 rtl/fp_scoreboard.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fp_scoreboard_if.sv
// Expected-vector and DUT-response bundle for fp_scoreboard.
// The master drives stimulus; the scoreboard is the slave.
interface fp_scoreboard_if;
    logic        exp_valid;
    logic        exp_ready;
    logic [63:0] exp_result;
    logic [4:0]  exp_flags;
    logic [1:0]  exp_fmt;
    logic        exp_f2i;
    logic        issue;
    logic        dut_ready;
    logic [63:0] dut_result;
    logic [4:0]  dut_flags;

    modport master (
        output exp_valid, exp_result, exp_flags,
        output exp_fmt, exp_f2i,
        output dut_ready, dut_result, dut_flags,
        input  exp_ready, issue
    );

    modport slave (
        input  exp_valid, exp_result, exp_flags,
        input  exp_fmt, exp_f2i,
        input  dut_ready, dut_result, dut_flags,
        output exp_ready, issue
    );
endinterface

// File: rtl/fp_scoreboard.sv
// In-order result scoreboard for an FP unit: queues expected
// vectors, compares DUT responses with NaN relaxation, counts.
module fp_scoreboard #(
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    fp_scoreboard_if.slave     sb,
    output logic               halted,
    output logic               mismatch,
    output logic               orphan,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [63:0]        err_result_diff,
    output logic [4:0]         err_flags_diff
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic        f2i;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    state_t           state_q, state_d;
    logic             mis_q, mis_d;
    logic             orph_q, orph_d;
    logic             cap_q, cap_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [63:0]      rdiff_q, rdiff_d;
    logic [4:0]       fdiff_q, fdiff_d;

    logic             empty, full;
    logic             push, pop, orphan_ev;
    logic             s_nan, d_nan;
    logic             cmp_fail, fail;
    logic [63:0]      res_diff;
    logic [4:0]       flg_diff;
    entry_t           head;
    entry_t           wr_ent;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign sb.exp_ready = reset && (state_q == RUN) &&
                          !full && !clear;
    assign sb.issue     = sb.exp_valid && sb.exp_ready;

    assign push      = sb.issue;
    assign pop       = sb.dut_ready && !empty;
    assign orphan_ev = sb.dut_ready && empty;

    assign head = mem_q[rd_q[AW-1:0]];

    assign wr_ent.result = sb.exp_result;
    assign wr_ent.flags  = sb.exp_flags;
    assign wr_ent.fmt    = sb.exp_fmt;
    assign wr_ent.f2i    = sb.exp_f2i;

    // Compare the head entry, relaxing canonical-NaN payloads.
    always_comb begin
        s_nan = (head.fmt == 2'd0) && !head.f2i &&
                (sb.dut_result[31:0] == 32'h7FC0_0000);
        d_nan = (head.fmt != 2'd0) && !head.f2i &&
                (sb.dut_result == 64'h7FF8_0000_0000_0000);
        res_diff = sb.dut_result ^ head.result;
        if (s_nan) begin
            res_diff = {32'h0, 1'b0,
                        sb.dut_result[30:22] ^ head.result[30:22],
                        22'h0};
        end else if (d_nan) begin
            res_diff = {1'b0,
                        sb.dut_result[62:51] ^ head.result[62:51],
                        51'h0};
        end
        flg_diff = sb.dut_flags ^ head.flags;
        cmp_fail = (res_diff != 64'h0) || (flg_diff != 5'h0);
        fail     = (pop && cmp_fail) || orphan_ev;
    end

    // Next-state for pointers, counters, capture and run/halt.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        state_d = state_q;
        mis_d   = 1'b0;
        orph_d  = orph_q;
        cap_d   = cap_q;
        pass_d  = pass_q;
        err_d   = err_q;
        rdiff_d = rdiff_q;
        fdiff_d = fdiff_q;
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            state_d = RUN;
            orph_d  = 1'b0;
            cap_d   = 1'b0;
            pass_d  = '0;
            err_d   = '0;
            rdiff_d = '0;
            fdiff_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (orphan_ev) orph_d = 1'b1;
            if (pop && !cmp_fail && pass_q != {CNT_W{1'b1}})
                pass_d = pass_q + 1'b1;
            if (fail && err_q != {CNT_W{1'b1}})
                err_d = err_q + 1'b1;
            if (pop && cmp_fail && !cap_q) begin
                cap_d   = 1'b1;
                rdiff_d = res_diff;
                fdiff_d = flg_diff;
            end
            mis_d = fail;
            if (fail && STOP_ON_ERR) state_d = HALT;
        end
    end

    // Expected-vector storage; written only on an accepted push.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q[AW-1:0]] <= wr_ent;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= RUN;
            mis_q   <= 1'b0;
            orph_q  <= 1'b0;
            cap_q   <= 1'b0;
            pass_q  <= '0;
            err_q   <= '0;
            rdiff_q <= '0;
            fdiff_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            mis_q   <= mis_d;
            orph_q  <= orph_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            rdiff_q <= rdiff_d;
            fdiff_q <= fdiff_d;
        end
    end

    assign halted          = (state_q == HALT);
    assign mismatch        = mis_q;
    assign orphan          = orph_q;
    assign pass_cnt        = pass_q;
    assign err_cnt         = err_q;
    assign err_result_diff = rdiff_q;
    assign err_flags_diff  = fdiff_q;

endmodule
